// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, FSM state encodings and the parity helper.
// Intended for reuse by both the configurable TX and the planned configurable RX.
package uart_pkg;

  // Parity mode codes used by the PARITY parameter
  localparam int unsigned PAR_NONE = 32'd0;
  localparam int unsigned PAR_EVEN = 32'd1;
  localparam int unsigned PAR_ODD  = 32'd2;

  // Widest data field supported by the frame format
  localparam int unsigned MAX_DATA_BITS = 32'd9;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity bit for a zero-extended data word; unused upper zeros do not affect XOR
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int unsigned mode);
    logic p;
    p = 1'b0;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: loadable down-counter that flags the last clock of each bit.
// The period is captured on restart so later changes to the divisor input are ignored.
module uart_baud_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_restart,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_bit_end
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: load on restart, otherwise count down and wrap while running
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (i_restart) begin
      period_d = i_period;
      cnt_d    = i_period - CNT_ONE;
    end else if (i_run) begin
      if (cnt_q == CNT_ZERO) begin
        cnt_d = period_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and captured period registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      period_q <= CNT_ZERO;
      cnt_q    <= CNT_ZERO;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

  // Last clock of the current bit
  assign o_bit_end = i_run && (cnt_q == CNT_ZERO);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits LSB first, optional even/odd
// parity, 1 or 2 stop bits, run-time bit-period divisor latched per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32'd8,
  parameter int unsigned PARITY    = 32'd0,
  parameter int unsigned STOP_BITS = 32'd1,
  parameter int unsigned CNT_W     = 32'd16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  // Reject frame formats the sequencer cannot produce
  if (DATA_BITS < 32'd5 || DATA_BITS > MAX_DATA_BITS || PARITY > PAR_ODD ||
      (STOP_BITS != 32'd1 && STOP_BITS != 32'd2) || CNT_W < 32'd2) begin : g_bad_cfg
    $error("uart_tx_cfg: illegal DATA_BITS/PARITY/STOP_BITS/CNT_W");
  end

  localparam int unsigned IDX_W = 32'd4;
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 32'd1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 32'd1);
  localparam logic [CNT_W-1:0] MIN_DIV   = {{(CNT_W-2){1'b0}}, 2'b10};

  uart_state_e            state_q, state_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   serial_q, serial_d;
  logic                   ready_q, ready_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;

  logic                   baud_restart;
  logic [CNT_W-1:0]       baud_period;
  logic                   bit_end;

  // Divisor clamp: anything below two clocks per bit becomes two
  always_comb begin
    if (i_Clks_Per_Bit < MIN_DIV) begin
      baud_period = MIN_DIV;
    end else begin
      baud_period = i_Clks_Per_Bit;
    end
  end

  uart_baud_gen #(
    .CNT_W (CNT_W)
  ) u_baud_gen (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_restart (baud_restart),
    .i_run     (state_q != ST_IDLE),
    .i_period  (baud_period),
    .o_bit_end (bit_end)
  );

  // Frame sequencer next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    serial_d     = serial_q;
    done_d       = 1'b0;
    baud_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Tx_DV) begin
          state_d      = ST_START;
          shift_d      = i_Tx_Byte;
          par_d        = calc_parity(MAX_DATA_BITS'(i_Tx_Byte), PARITY);
          bit_idx_d    = IDX_ZERO;
          serial_d     = 1'b0;
          baud_restart = 1'b1;
        end else begin
          serial_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = IDX_ZERO;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = IDX_ZERO;
            if (PARITY != PAR_NONE) begin
              state_d  = ST_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          serial_d  = 1'b1;
          bit_idx_d = IDX_ZERO;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            serial_d  = 1'b1;
            bit_idx_d = IDX_ZERO;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        serial_d  = 1'b1;
        bit_idx_d = IDX_ZERO;
      end
    endcase
    ready_d  = (state_d == ST_IDLE);
    active_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered line/status outputs
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= IDX_ZERO;
      shift_q   <= {DATA_BITS{1'b0}};
      par_q     <= 1'b0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      serial_q  <= serial_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three frame formats (8N1, 7E2, 9O1) with
// hand-computed line sequences, listed start bit first.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  dv;
  logic [8:0]  tx_byte;
  logic [15:0] div;
  logic [2:0]  ser, rdy, act, done;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(16)) u_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div), .i_Tx_DV(dv[0]),
    .i_Tx_Byte(tx_byte[7:0]), .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]),
    .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));

  uart_tx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CNT_W(16)) u_7e2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div), .i_Tx_DV(dv[1]),
    .i_Tx_Byte(tx_byte[6:0]), .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]),
    .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));

  uart_tx_cfg #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .CNT_W(16)) u_9o1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div), .i_Tx_DV(dv[2]),
    .i_Tx_Byte(tx_byte), .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]),
    .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));

  // Count Done pulses of the 8N1 instance, sampled mid-cycle
  always @(negedge clk) begin
    if (done[0]) done_cnt0 <= done_cnt0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and divisor with DV high across one rising edge; DV stays high
  task automatic accept(input logic [1:0] sel, input logic [8:0] b, input logic [15:0] n);
    tx_byte = b;
    div     = n;
    dv[sel] = 1'b1;
    tick();
  endtask

  // Follow one frame cycle by cycle from the first cycle after accept, then check completion
  task automatic run_frame(input logic [1:0] sel, input logic [15:0] bits, input int nbits,
                           input int n, input int drop_at, input string tag);
    int line_err = 0;
    int stat_err = 0;
    logic [3:0] bidx;
    for (int c = 0; c < nbits * n; c++) begin
      bidx = 4'(nbits - 1 - c / n);
      if (ser[sel] !== bits[bidx]) line_err++;
      if (rdy[sel] !== 1'b0 || act[sel] !== 1'b1 || done[sel] !== 1'b0) stat_err++;
      if (c == drop_at) dv[sel] = 1'b0;
      tick();
    end
    check({tag, "_line_errs"}, 32'(line_err), 32'd0);
    check({tag, "_busy_errs"}, 32'(stat_err), 32'd0);
    check({tag, "_done"},   32'(done[sel]), 32'd1);
    check({tag, "_ready"},  32'(rdy[sel]),  32'd1);
    check({tag, "_active"}, 32'(act[sel]),  32'd0);
    check({tag, "_idle_hi"}, 32'(ser[sel]), 32'd1);
  endtask

  initial begin
    int base;
    rst_n   = 1'b0;
    dv      = 3'b000;
    tx_byte = 9'h000;
    div     = 16'd4;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_serial", 32'(ser[i]),  32'd1);
      check("rst_ready",  32'(rdy[i]),  32'd1);
      check("rst_active", 32'(act[i]),  32'd0);
      check("rst_done",   32'(done[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // 8N1 0xA5, N=4: Done lands 40 cycles after accept
    accept(2'd0, 9'h0A5, 16'd4);
    run_frame(2'd0, 16'b0101001011, 10, 4, 0, "8n1_a5");
    tick();

    // 7E2 0x55, N=3: even parity 0, two stop bits, 33 clocks
    accept(2'd1, 9'h055, 16'd3);
    run_frame(2'd1, 16'b01010101011, 11, 3, 0, "7e2_55");
    tick();

    // 9O1 0x1FF -> parity 0; 0x000 -> parity 1
    accept(2'd2, 9'h1FF, 16'd2);
    run_frame(2'd2, 16'b011111111101, 12, 2, 0, "9o1_1ff");
    tick();
    accept(2'd2, 9'h000, 16'd2);
    run_frame(2'd2, 16'b000000000011, 12, 2, 0, "9o1_000");
    tick();

    // Back-to-back 0x12 then 0x34 with DV held; byte change mid-frame is ignored
    base = done_cnt0;
    accept(2'd0, 9'h012, 16'd4);
    tx_byte = 9'h034;
    run_frame(2'd0, 16'b0010010001, 10, 4, -1, "b2b_12");
    tick();
    run_frame(2'd0, 16'b0001011001, 10, 4, 0, "b2b_34");
    repeat (3) tick();
    check("b2b_done_pulses", 32'(done_cnt0 - base), 32'd2);

    // Divisor 4 -> 8 mid-frame, plus DV held while busy must not queue
    accept(2'd0, 9'h0A5, 16'd4);
    div     = 16'd8;
    tx_byte = 9'h03C;
    run_frame(2'd0, 16'b0101001011, 10, 4, 5, "div4_keep");
    tick();
    check("no_queue_serial", 32'(ser[0]), 32'd1);
    check("no_queue_ready",  32'(rdy[0]), 32'd1);
    accept(2'd0, 9'h0A5, 16'd8);
    run_frame(2'd0, 16'b0101001011, 10, 8, 0, "div8");
    tick();

    // Divisors 0 and 1 clamp to 2 clocks per bit
    accept(2'd0, 9'h012, 16'd0);
    run_frame(2'd0, 16'b0010010001, 10, 2, 0, "div0");
    tick();
    accept(2'd0, 9'h034, 16'd1);
    run_frame(2'd0, 16'b0001011001, 10, 2, 0, "div1");
    tick();

    // Reset in the middle of the data bits aborts at once with no Done
    base = done_cnt0;
    accept(2'd0, 9'h0A5, 16'd4);
    dv[0] = 1'b0;
    repeat (10) tick();
    check("pre_rst_active", 32'(act[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_serial", 32'(ser[0]),  32'd1);
    check("mid_rst_ready",  32'(rdy[0]),  32'd1);
    check("mid_rst_active", 32'(act[0]),  32'd0);
    check("mid_rst_done",   32'(done[0]), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    check("rst_no_done", 32'(done_cnt0 - base), 32'd0);
    accept(2'd0, 9'h0A5, 16'd4);
    run_frame(2'd0, 16'b0101001011, 10, 4, 0, "post_rst");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
